seg_display_ctrl: RTL

Controller that owns the board's four 7-segment hex digits and shares them between two requesters: the core status path and the debug path. It latches a 16-bit word per transaction through a valid/ready handshake and enforces a minimum visible hold time per update. It also applies optional blink and leading-zero blanking, then drives four instances of the nibble-to-segment decoder.

---
 rtl/seg_display_pkg.sv | 16 +
 rtl/SegDisplay.sv | 30 +++
 rtl/seg_display_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared constants and types for the hex display controller
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_DARK  = 7'h7F;
  localparam logic [6:0] SEG_RESET = 7'h40;

  typedef enum logic {SRC_CORE = 1'b0, SRC_DBG = 1'b1} src_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/SegDisplay.sv
// rtl/SegDisplay.sv - nibble to 7-segment decoder, active-low, bit order gfedcba
module SegDisplay (
  input  logic [3:0] inNibble,
  output logic [6:0] outSegs
);

  always_comb begin
    outSegs = 7'h7F;
    case (inNibble)
      4'h0: outSegs = ~7'h3F;
      4'h1: outSegs = ~7'h06;
      4'h2: outSegs = ~7'h5B;
      4'h3: outSegs = ~7'h4F;
      4'h4: outSegs = ~7'h66;
      4'h5: outSegs = ~7'h6D;
      4'h6: outSegs = ~7'h7D;
      4'h7: outSegs = ~7'h07;
      4'h8: outSegs = ~7'h7F;
      4'h9: outSegs = ~7'h6F;
      4'hA: outSegs = ~7'h77;
      4'hB: outSegs = ~7'h7C;
      4'hC: outSegs = ~7'h39;
      4'hD: outSegs = ~7'h5E;
      4'hE: outSegs = ~7'h79;
      4'hF: outSegs = ~7'h71;
      default: outSegs = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - shares four hex digits between core and debug requesters
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic        inClk,
  input  logic        inRst,
  input  logic        inCoreVld,
  input  logic [15:0] inCoreWord,
  output logic        outCoreRdy,
  input  logic        inDbgVld,
  input  logic [15:0] inDbgWord,
  input  logic        inDbgBlink,
  output logic        outDbgRdy,
  input  logic        inBlankZeros,
  output logic [27:0] outSegs,
  output logic        outSrc
);

  localparam int WORD_W = 4 * NUM_DIGITS;
  localparam int SEG_W  = 7 * NUM_DIGITS;
  localparam int HW     = cntWidth(HOLD_CYCLES);
  localparam int BW     = cntWidth(BLINK_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t              state;
  state_t              stateNext;
  logic [WORD_W-1:0]   word;
  src_t                src;
  logic                blinkEn;
  logic                phaseOn;
  logic [HW-1:0]       holdCnt;
  logic [BW-1:0]       blinkCnt;
  logic                dbgAcc;
  logic                coreAcc;
  logic [6:0]          decSegs [NUM_DIGITS];
  logic [SEG_W-1:0]    segsNext;

  // Debug wins ties; the core ready is masked by the debug valid, never by its own.
  always_comb begin
    stateNext  = state;
    outDbgRdy  = 1'b0;
    outCoreRdy = 1'b0;
    dbgAcc     = 1'b0;
    coreAcc    = 1'b0;
    case (state)
      ST_IDLE: begin
        outDbgRdy  = 1'b1;
        outCoreRdy = ~inDbgVld;
        dbgAcc     = inDbgVld;
        coreAcc    = inCoreVld & ~inDbgVld;
        if (dbgAcc || coreAcc) stateNext = ST_HOLD;
      end
      ST_HOLD: begin
        if (holdCnt == '0) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      word    <= '0;
      src     <= SRC_CORE;
      blinkEn <= 1'b0;
      holdCnt <= '0;
    end else if (dbgAcc) begin
      word    <= inDbgWord;
      src     <= SRC_DBG;
      blinkEn <= inDbgBlink;
      holdCnt <= HOLD_LOAD;
    end else if (coreAcc) begin
      word    <= inCoreWord;
      src     <= SRC_CORE;
      blinkEn <= 1'b0;
      holdCnt <= HOLD_LOAD;
    end else if (state == ST_HOLD && holdCnt != '0) begin
      holdCnt <= holdCnt - HW'(1);
    end
  end

  // Blink keeps running after the hold expires, until the next accept restarts it.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      blinkCnt <= '0;
      phaseOn  <= 1'b1;
    end else if (dbgAcc || coreAcc) begin
      blinkCnt <= '0;
      phaseOn  <= 1'b1;
    end else if (blinkEn) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        phaseOn  <= ~phaseOn;
      end else begin
        blinkCnt <= blinkCnt + BW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    SegDisplay uDec (
      .inNibble (word[4*g +: 4]),
      .outSegs  (decSegs[g])
    );
    if (g == 0) begin : gen_lsd
      assign segsNext[6:0] = phaseOn ? decSegs[0] : SEG_DARK;
    end else begin : gen_upper
      logic leadZero;
      assign leadZero = inBlankZeros && (word[WORD_W-1:4*g] == '0);
      assign segsNext[7*g +: 7] = (!phaseOn || leadZero) ? SEG_DARK : decSegs[g];
    end
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) outSegs <= {NUM_DIGITS{SEG_RESET}};
    else       outSegs <= segsNext;
  end

  assign outSrc = (src == SRC_DBG);

endmodule
